// File: rtl/branch_pkg.sv
// Shared types for the branch controller: operation codes, FSM states and flag bit positions.
package branch_pkg;

    typedef enum logic [2:0] {
        OpJmp  = 3'd0,
        OpBr   = 3'd1,
        OpBz   = 3'd2,
        OpBnz  = 3'd3,
        OpBn   = 3'd4,
        OpBc   = 3'd5,
        OpCall = 3'd6,
        OpRet  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagC = 0;

    // Absolute transfers load the PC; every other op adds an offset.
    function automatic logic is_load(op_e op);
        return (op == OpJmp) || (op == OpCall) || (op == OpRet);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses with a combinational top-of-stack read.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]  wr_idx;
    logic [IdxW-1:0]  top_idx;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_idx  = IdxW'(count_q);
    assign top_idx = IdxW'(count_q - CntW'(1));
    assign top     = empty ? '0 : mem_q[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !full) begin
            mem_q[wr_idx] <= push_data;
            count_q       <= count_q + CntW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CntW'(1);
        end
    end

endmodule

// File: rtl/branch_control.sv
// Resolves execute-stage control-flow requests into registered PC load/offset strobes,
// with a return-address stack for CALL/RET and a post-transfer pipeline flush.
module branch_control
    import branch_pkg::*;
#(
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_target,
    input  logic [8:0]  req_offset,
    input  logic [2:0]  flags,
    input  logic [15:0] pc_value,
    output logic        load_enable,
    output logic [15:0] load_value,
    output logic        offset_enable,
    output logic [8:0]  offset,
    output logic        resolved,
    output logic        taken,
    output logic        flush,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e          state_q;
    op_e             op_q;
    op_e             op_in;
    logic [15:0]     ret_addr_q;
    logic [CntW-1:0] cnt_q;
    logic            take;
    logic            stk_push;
    logic            stk_pop;
    logic [15:0]     stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign op_in = op_e'(req_op);

    // Condition is evaluated on accept; the stack cannot change until ISSUE ends.
    always_comb begin
        take = 1'b0;
        case (op_in)
            OpJmp:   take = 1'b1;
            OpBr:    take = 1'b1;
            OpBz:    take = flags[FlagZ];
            OpBnz:   take = !flags[FlagZ];
            OpBn:    take = flags[FlagN];
            OpBc:    take = flags[FlagC];
            OpCall:  take = !stk_full;
            OpRet:   take = !stk_empty;
            default: take = 1'b0;
        endcase
    end

    assign stk_push = (state_q == StIssue) && (op_q == OpCall) && taken;
    assign stk_pop  = (state_q == StIssue) && (op_q == OpRet) && taken;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (16)
    ) u_return_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (ret_addr_q),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            op_q            <= OpJmp;
            ret_addr_q      <= '0;
            cnt_q           <= '0;
            req_ready       <= 1'b0;
            load_enable     <= 1'b0;
            load_value      <= '0;
            offset_enable   <= 1'b0;
            offset          <= '0;
            resolved        <= 1'b0;
            taken           <= 1'b0;
            flush           <= 1'b0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        state_q    <= StIssue;
                        op_q       <= op_in;
                        ret_addr_q <= pc_value + 16'd1;
                        resolved   <= 1'b1;
                        taken      <= take;
                        if (take && is_load(op_in)) begin
                            load_enable <= 1'b1;
                            load_value  <= (op_in == OpRet) ? stk_top : req_target;
                        end else if (take) begin
                            offset_enable <= 1'b1;
                            offset        <= req_offset;
                        end
                    end
                end
                StIssue: begin
                    load_enable   <= 1'b0;
                    load_value    <= '0;
                    offset_enable <= 1'b0;
                    offset        <= '0;
                    resolved      <= 1'b0;
                    taken         <= 1'b0;
                    if (op_q == OpCall && !taken) stack_overflow <= 1'b1;
                    if (op_q == OpRet && !taken) stack_underflow <= 1'b1;
                    if (taken && FLUSH_CYCLES > 0) begin
                        state_q <= StFlush;
                        flush   <= 1'b1;
                        cnt_q   <= CntW'(FLUSH_CYCLES - 1);
                    end else begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end
                end
                StFlush: begin
                    if (cnt_q == '0) begin
                        flush     <= 1'b0;
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
